// File: rtl/uart_tx_fsm_if.sv
// Byte-level request bus between the system controller and the UART TX.
//   master (controller): drives p_data, data_valid, par_en, par_typ, prescale;
//                        observes tx_out, busy.
//   slave  (uart_tx_fsm): the reverse.
interface uart_tx_fsm_if #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
);
  logic [DATA_WIDTH-1:0]     p_data;
  logic                      data_valid;
  logic                      par_en;
  logic                      par_typ;
  logic [PRESCALE_WIDTH-1:0] prescale;
  logic                      tx_out;
  logic                      busy;

  modport master (
    output p_data, data_valid, par_en, par_typ, prescale,
    input  tx_out, busy
  );

  modport slave (
    input  p_data, data_valid, par_en, par_typ, prescale,
    output tx_out, busy
  );
endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional
// parity bit, one stop bit. Each bit is held for 'prescale' CLK cycles
// (0 behaves as 1), so no external baud tick is required.
// Ports:
//   CLK  - system clock, rising edge
//   RST  - synchronous active-high reset
//   bus  - slave side of uart_tx_fsm_if (byte request in, tx_out/busy out)
module uart_tx_fsm #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic           CLK,
  input  logic           RST,
  uart_tx_fsm_if.slave   bus
);

  localparam int BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] edge_cnt;
  logic [BCW-1:0]            bit_cnt;
  logic [DATA_WIDTH-1:0]     data_q;
  logic                      par_en_q;
  logic                      par_q;
  logic [PRESCALE_WIDTH-1:0] presc_q;

  logic           bit_end;
  logic [BCW-1:0] bit_nxt;

  // presc_q is never 0 outside IDLE, so P-1 cannot underflow while it matters.
  assign bit_end = (edge_cnt == presc_q - 1'b1);
  assign bit_nxt = bit_cnt + 1'b1;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_q      <= 1'b0;
      presc_q    <= '0;
      bus.tx_out <= 1'b1;
      bus.busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          bus.tx_out <= 1'b1;
          bus.busy   <= 1'b0;
          edge_cnt   <= '0;
          bit_cnt    <= '0;
          if (bus.data_valid) begin
            // Snapshot everything so later input changes cannot touch the frame.
            data_q     <= bus.p_data;
            par_en_q   <= bus.par_en;
            par_q      <= bus.par_typ ? ~^bus.p_data : ^bus.p_data;
            presc_q    <= (bus.prescale == '0) ? PRESCALE_WIDTH'(1) : bus.prescale;
            state      <= START;
            bus.tx_out <= 1'b0;
            bus.busy   <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            state      <= DATA;
            bus.tx_out <= data_q[0];
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            edge_cnt <= '0;
            if (bit_cnt == BCW'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              if (par_en_q) begin
                state      <= PARITY;
                bus.tx_out <= par_q;
              end else begin
                state      <= STOP;
                bus.tx_out <= 1'b1;
              end
            end else begin
              // Output is registered, so present the next bit one edge early.
              bit_cnt    <= bit_nxt;
              bus.tx_out <= data_q[bit_nxt];
            end
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end

        PARITY: begin
          if (bit_end) begin
            edge_cnt   <= '0;
            state      <= STOP;
            bus.tx_out <= 1'b1;
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end

        STOP: begin
          if (bit_end) begin
            edge_cnt   <= '0;
            state      <= IDLE;
            bus.tx_out <= 1'b1;
            bus.busy   <= 1'b0;
          end else begin
            edge_cnt <= edge_cnt + 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          edge_cnt   <= '0;
          bit_cnt    <= '0;
          bus.tx_out <= 1'b1;
          bus.busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Directed bench for uart_tx_fsm: drives byte requests through the interface
// and checks tx_out/busy cycle by cycle against hand-derived frames.
module tb_uart_tx_fsm;

  logic CLK = 1'b0;
  logic RST;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 CLK = ~CLK;

  uart_tx_fsm_if #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) bus ();

  uart_tx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sample idle line for n cycles.
  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      chk($sformatf("%s tx c%0d", tag, i), bus.tx_out, 1'b1);
      chk($sformatf("%s busy c%0d", tag, i), bus.busy, 1'b0);
    end
  endtask

  // Present a request on a negedge; it is accepted at the following posedge.
  task automatic accept(input logic [7:0] d, input logic pe, input logic pt,
                        input logic [5:0] ps, input logic hold);
    @(negedge CLK);
    bus.p_data     = d;
    bus.par_en     = pe;
    bus.par_typ    = pt;
    bus.prescale   = ps;
    bus.data_valid = 1'b1;
    @(posedge CLK);
    #1;
    if (!hold) bus.data_valid = 1'b0;
  endtask

  // Check every cycle of one frame. poke_k/clear_k let a test disturb the
  // inputs at a given cycle of the frame.
  task automatic check_frame(input string tag, input logic [7:0] d, input logic pe,
                             input logic par, input int p, input int poke_k,
                             input logic [7:0] poke_d, input int clear_k);
    int   n;
    int   b;
    logic e;
    n = p * (pe ? 11 : 10);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      b = k / p;
      if (b == 0)            e = 1'b0;
      else if (b <= 8)       e = d[b-1];
      else if (b == 9 && pe) e = par;
      else                   e = 1'b1;
      chk($sformatf("%s tx k%0d", tag, k), bus.tx_out, e);
      chk($sformatf("%s busy k%0d", tag, k), bus.busy, 1'b1);
      if (k == poke_k) begin
        bus.p_data     = poke_d;
        bus.data_valid = 1'b1;
      end
      if (k == clear_k) bus.data_valid = 1'b0;
    end
  endtask

  initial begin
    RST            = 1'b1;
    bus.p_data     = '0;
    bus.data_valid = 1'b0;
    bus.par_en     = 1'b0;
    bus.par_typ    = 1'b0;
    bus.prescale   = '0;

    // 1: reset, then idle
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("rst tx", bus.tx_out, 1'b1);
      chk("rst busy", bus.busy, 1'b0);
    end
    RST = 1'b0;
    check_idle("idle0", 5);

    // 2: 0xA5, even parity (4 ones -> 0), P=8, 88 busy cycles
    accept(8'hA5, 1'b1, 1'b0, 6'd8, 1'b0);
    check_frame("a5", 8'hA5, 1'b1, 1'b0, 8, -1, 8'h00, -1);
    check_idle("a5 end", 3);

    // 3: 0x07 odd parity -> 0, then even parity -> 1, P=16
    accept(8'h07, 1'b1, 1'b1, 6'd16, 1'b0);
    check_frame("07odd", 8'h07, 1'b1, 1'b0, 16, -1, 8'h00, -1);
    check_idle("07odd end", 2);
    accept(8'h07, 1'b1, 1'b0, 6'd16, 1'b0);
    check_frame("07even", 8'h07, 1'b1, 1'b1, 16, -1, 8'h00, -1);
    check_idle("07even end", 2);

    // 4: 0x00 no parity, P=16; 0xFF pulse mid-frame must be ignored
    accept(8'h00, 1'b0, 1'b0, 6'd16, 1'b0);
    check_frame("00", 8'h00, 1'b0, 1'b0, 16, 50, 8'hFF, 51);
    check_idle("00 end", 20);

    // 5: data_valid held; p_data changes mid-frame to 0xC3
    accept(8'h3C, 1'b0, 1'b0, 6'd8, 1'b1);
    check_frame("3c", 8'h3C, 1'b0, 1'b0, 8, 20, 8'hC3, -1);
    check_idle("gap", 1);
    check_frame("c3", 8'hC3, 1'b0, 1'b0, 8, -1, 8'h00, 0);
    check_idle("c3 end", 4);

    // 6: reset at cycle 40 of a frame, then a clean frame, then prescale=0
    accept(8'h5A, 1'b0, 1'b0, 6'd8, 1'b0);
    for (int i = 0; i < 39; i++) @(negedge CLK);
    chk("mid busy", bus.busy, 1'b1);
    RST = 1'b1;
    @(posedge CLK);
    #1 RST = 1'b0;
    check_idle("after rst", 20);
    accept(8'h5A, 1'b1, 1'b0, 6'd8, 1'b0);
    check_frame("5a", 8'h5A, 1'b1, 1'b0, 8, -1, 8'h00, -1);
    check_idle("5a end", 2);
    accept(8'h96, 1'b1, 1'b1, 6'd0, 1'b0);
    check_frame("96p0", 8'h96, 1'b1, 1'b1, 1, -1, 8'h00, -1);
    check_idle("96 end", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
Name: uart_tx_fsm

Overview:
UART transmitter that pairs with the existing UART receive path. It accepts one byte per handshake and serialises it as a frame: start bit, 8 data bits (LSB first), optional parity bit, one stop bit. Each bit is held for a programmable number of CLK cycles, so no external baud-tick logic is needed. It sits between the system controller's TX-byte output and the UART TX pin.

Parameters:
DATA_WIDTH, 8, number of data bits per frame.
PRESCALE_WIDTH, 6, width of the prescale input and the edge counter.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RST  input  1  synchronous active-high reset.
p_data  input  DATA_WIDTH  byte to transmit.
data_valid  input  1  request to transmit p_data.
par_en  input  1  1 = insert a parity bit.
par_typ  input  1  0 = even parity, 1 = odd parity.
prescale  input  PRESCALE_WIDTH  CLK cycles per bit; 0 is treated as 1.
tx_out  output  1  serial line; idle high.
busy  output  1  high while a frame is in flight.

Behaviour:
- Clocking/reset: one clock (CLK); reset is synchronous and active-high (RST). While RST=1 at a rising edge: state=IDLE, tx_out=1, busy=0, edge and bit counters=0, and the latched data/config registers=0.
- Reset mid-frame: the frame is abandoned. tx_out=1 and busy=0 from the first edge with RST=1. No partial bits resume after reset.
- Outputs are registered: tx_out and busy come straight from flops, with no combinational path from the inputs.
- Acceptance: at a rising edge with state=IDLE and data_valid=1, latch p_data, par_en, par_typ and the effective prescale (0→1). Compute parity from the latched byte: even = XOR of bits, odd = XNOR of bits. data_valid is ignored in every other state. Input changes after acceptance do not affect the frame in flight.
- Latency: the start bit (tx_out=0) and busy=1 appear at the edge after acceptance (1-cycle latency).
- States:
  - IDLE: tx_out=1, busy=0.
  - START: drives 0.
  - DATA: drives latched bit[bit_cnt], with bit_cnt running 0..DATA_WIDTH-1.
  - PARITY: drives the latched parity bit.
  - STOP: drives 1.
- Bit timing: the edge counter counts 0..P-1 in each bit state, where P is the latched prescale. The state advances when the counter reaches P-1, and the counter returns to 0 on every transition.
- Transitions:
  - START→DATA after P cycles.
  - DATA stays until bit_cnt=DATA_WIDTH-1 and edge=P-1.
  - DATA→PARITY if latched par_en=1, otherwise DATA→STOP.
  - PARITY→STOP after P cycles.
  - STOP→IDLE after P cycles.
- Frame duration: busy is high for exactly P*(10+par_en) consecutive cycles.
- Back-to-back: busy drops for one cycle in IDLE. A data_valid held high is accepted in that IDLE cycle, so a minimum of 1 cycle of high line (beyond the stop bit) separates frames.
- Illegal states: unencoded state values return to IDLE with tx_out=1 and busy=0 on the next edge.
- Widths: bit_cnt is $clog2(DATA_WIDTH) bits and the edge counter is PRESCALE_WIDTH bits. Neither counter may wrap within a bit; the max prescale of 2^PRESCALE_WIDTH-1 is legal.

Test Plan:
1. Reset then idle: RST=1 for 3 cycles, then 0 with data_valid=0 → tx_out=1 and busy=0 on every cycle.
2. p_data=0xA5, par_en=1, par_typ=0, prescale=8, one-cycle data_valid → from the next edge, 8-cycle bits 0,1,0,1,0,0,1,0,1,0(parity),1. busy high for exactly 88 cycles, then busy=0 and tx_out=1.
3. p_data=0x07, par_en=1, par_typ=1, prescale=16 → parity bit=0 (odd parity, three ones). busy for 176 cycles. Then repeat with par_typ=0 → parity bit=1.
4. p_data=0x00, par_en=0, prescale=16 → tx_out=0 for 144 cycles, then 1 for 16. busy for 160 cycles. A data_valid pulse mid-frame carrying 0xFF is ignored (no second frame).
5. data_valid held high with 0x3C then 0xC3 (changed mid-frame), prescale=8, par_en=0 → frame 1 carries 0x3C. busy low for exactly 1 cycle. Frame 2 carries 0xC3.
6. Start a frame with prescale=8, assert RST=1 for 1 cycle at cycle 40 → next edge tx_out=1 and busy=0. A new data_valid after reset transmits a complete, correct frame. Also prescale=0 → every bit lasts 1 cycle.
